stage_wb: RTL

//  Write-back stage directly downstream of the memory stage. Registers the MEM/WB result and

---
 rtl/stage_wb.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/stage_wb.sv
// -----------------------------------------------------------------------------
// stage_wb : pipeline write-back stage, directly downstream of the memory stage.
//
// Registers the MEM/WB result, picks load data or the ALU result, and drives
// the register-file write port (which doubles as the forwarding source).
// A memory-stage exception becomes a trap request that is held, and that stalls
// the pipe, until the CSR unit acknowledges it.
//
// Build option:
//   STAGE_WB_INSTRET_EN  defined     -> 64-bit retired-instruction counter on instret_o
//                        not defined -> instret_o tied to 0, no counter logic
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   valid_i, flush_i                  MEM instruction present / discard it
//   pc_i, rd_i, rd_we_i               PC, destination register, rd write request
//   is_ld_i, is_st_i                  load / store flags
//   alu_res_i, ld_data_i              ALU result (or address) / formatted load data
//   e_ld_mis_i, e_st_mis_i, e_bus_err_i  memory-stage exceptions
//   trap_ack_i                        CSR unit accepted the trap
//   wb_we_o, wb_rd_o, wb_dat_o        register-file write port
//   retired_o                         one-cycle pulse per retired instruction
//   trap_valid_o, trap_cause_o,
//   trap_pc_o, trap_tval_o            held trap request to the CSR unit
//   wb_stall_o                        stall upstream stages
//   instret_o                         retired-instruction count
//
// FSM states:
//   state   | meaning
//   RUN     | normal flow, MEM results are captured each cycle
//   TRAP    | trap request held, pipe stalled, MEM inputs ignored
// -----------------------------------------------------------------------------
module stage_wb #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              rd_we_i,
    input  logic              is_ld_i,
    input  logic              is_st_i,
    input  logic [XLEN-1:0]   alu_res_i,
    input  logic [XLEN-1:0]   ld_data_i,
    input  logic              e_ld_mis_i,
    input  logic              e_st_mis_i,
    input  logic              e_bus_err_i,
    input  logic              trap_ack_i,
    output logic              wb_we_o,
    output logic [REG_AW-1:0] wb_rd_o,
    output logic [XLEN-1:0]   wb_dat_o,
    output logic              retired_o,
    output logic              trap_valid_o,
    output logic [3:0]        trap_cause_o,
    output logic [XLEN-1:0]   trap_pc_o,
    output logic [XLEN-1:0]   trap_tval_o,
    output logic              wb_stall_o,
    output logic [63:0]       instret_o
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_retire;
    logic              w_take_trap;
    logic              w_exc_any;
    logic [3:0]        w_cause;

    logic              r_wb_we;
    logic [REG_AW-1:0] r_wb_rd;
    logic [XLEN-1:0]   r_wb_dat;
    logic              r_retired;
    logic [3:0]        r_trap_cause;
    logic [XLEN-1:0]   r_trap_pc;
    logic [XLEN-1:0]   r_trap_tval;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_retire    = 1'b0;
        w_take_trap = 1'b0;
        w_exc_any   = e_ld_mis_i | e_st_mis_i | e_bus_err_i;
        // Misalignment wins over a bus error; a bus error is classified by access type.
        if (e_ld_mis_i) begin
            w_cause = 4'd4;
        end else if (e_st_mis_i) begin
            w_cause = 4'd6;
        end else if (is_ld_i) begin
            w_cause = 4'd5;
        end else begin
            w_cause = 4'd7;
        end
        case (r_state)
            ST_RUN: begin
                if (valid_i && !flush_i) begin
                    if (w_exc_any) begin
                        w_take_trap = 1'b1;
                        w_state_nxt = ST_TRAP;
                    end else begin
                        w_retire = 1'b1;
                    end
                end
            end
            ST_TRAP: begin
                // The ack cycle captures nothing: the CSR unit flushes the pipe.
                if (trap_ack_i) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wb_we      <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_dat     <= '0;
            r_retired    <= 1'b0;
            r_trap_cause <= 4'd0;
            r_trap_pc    <= '0;
            r_trap_tval  <= '0;
        end else begin
            r_wb_we   <= w_retire && rd_we_i && !is_st_i && (rd_i != '0);
            r_retired <= w_retire;
            if (w_retire) begin
                r_wb_rd  <= rd_i;
                r_wb_dat <= is_ld_i ? ld_data_i : alu_res_i;
            end
            if (w_take_trap) begin
                r_trap_cause <= w_cause;
                r_trap_pc    <= pc_i;
                r_trap_tval  <= alu_res_i;
            end
        end
    end

`ifdef STAGE_WB_INSTRET_EN
    logic [63:0] r_instret;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_instret <= 64'd0;
        end else if (r_retired) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign instret_o = r_instret;
`else
    assign instret_o = 64'd0;
`endif

    assign wb_we_o      = r_wb_we;
    assign wb_rd_o      = r_wb_rd;
    assign wb_dat_o     = r_wb_dat;
    assign retired_o    = r_retired;
    assign trap_valid_o = (r_state == ST_TRAP);
    assign wb_stall_o   = (r_state == ST_TRAP);
    assign trap_cause_o = r_trap_cause;
    assign trap_pc_o    = r_trap_pc;
    assign trap_tval_o  = r_trap_tval;

endmodule
